wb_puls_ctrl: RTL and testbench

//  Wishbone slave that conditions N push-button inputs: 2-FF synchroniser, per-channel

---
 rtl/wb_puls_pkg.sv | 12 +
 rtl/puls_debounce.sv | 51 +++++
 rtl/wb_puls_ctrl.sv | 108 ++++++++++
 tb/tb_wb_puls_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_puls_pkg.sv
// Shared constants for the push-button conditioning slave: register map and default widths.
package wb_puls_pkg;

    localparam logic [7:0] ADR_LEVEL   = 8'h00;
    localparam logic [7:0] ADR_PEND    = 8'h04;
    localparam logic [7:0] ADR_IRQ_EN  = 8'h08;
    localparam logic [7:0] ADR_EDGE    = 8'h0C;
    localparam logic [7:0] ADR_DEB_CFG = 8'h10;

    localparam int DEB_W_DEF = 16;

endpackage

// File: rtl/puls_debounce.sv
// One button channel: 2-FF synchroniser, stability counter and debounced level,
// with single-cycle rise/fall flags asserted on the cycle the level is about to change.
module puls_debounce
    import wb_puls_pkg::*;
#(
    parameter int DEB_W = DEB_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             puls,
    input  logic [DEB_W-1:0] deb_cfg,
    output logic             level,
    output logic             rise,
    output logic             fall
);

    logic             sync_a;
    logic             sync_b;
    logic [DEB_W-1:0] cnt;
    logic [DEB_W:0]   cnt_inc;
    logic             differ;
    logic             update;

    // One extra bit keeps the threshold compare correct even at an all-ones count
    assign cnt_inc = {1'b0, cnt} + (DEB_W+1)'(1);
    assign differ  = (sync_b != level);
    assign update  = differ && (cnt_inc >= {1'b0, deb_cfg});
    assign rise    = update & sync_b;
    assign fall    = update & ~sync_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_a <= puls;
            sync_b <= sync_a;
            if (!differ) begin
                cnt <= '0;
            end else if (update) begin
                level <= sync_b;
                cnt   <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt_inc[DEB_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_puls_ctrl.sv
// Wishbone slave conditioning N push buttons into debounced levels, sticky edge
// events and a masked level interrupt for the CPU.
module wb_puls_ctrl
    import wb_puls_pkg::*;
#(
    parameter int          N_PULS  = 2,
    parameter int          DEB_W   = DEB_W_DEF,
    parameter int unsigned DEB_RST = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              intr,
    input  logic [N_PULS-1:0] puls_in
);

    logic              ack;
    logic              access;
    logic              wr;
    logic [7:0]        adr;
    logic [31:0]       rd_data;
    logic [N_PULS-1:0] level;
    logic [N_PULS-1:0] rise;
    logic [N_PULS-1:0] fall;
    logic [N_PULS-1:0] ev;
    logic [N_PULS-1:0] pend;
    logic [N_PULS-1:0] pend_clr;
    logic [N_PULS-1:0] irq_en;
    logic [N_PULS-1:0] edge_cfg;
    logic [DEB_W-1:0]  deb_cfg;
    logic              unused_bits;

    // Byte selects and upper address bits carry no meaning for this slave
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_dat_i};

    for (genvar i = 0; i < N_PULS; i++) begin : g_deb
        puls_debounce #(.DEB_W(DEB_W)) u_deb (
            .clk     (clk),
            .reset   (reset),
            .puls    (puls_in[i]),
            .deb_cfg (deb_cfg),
            .level   (level[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign adr      = wb_adr_i[7:0];
    assign access   = wb_stb_i & wb_cyc_i & ~ack;
    assign wr       = access & wb_we_i;
    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack;
    assign ev       = (rise & edge_cfg) | (fall & ~edge_cfg);
    assign pend_clr = (wr && adr == ADR_PEND) ? wb_dat_i[N_PULS-1:0] : '0;
    assign intr     = |(pend & irq_en);

    always_comb begin
        rd_data = '0;
        case (adr)
            ADR_LEVEL:   rd_data[N_PULS-1:0] = level;
            ADR_PEND:    rd_data[N_PULS-1:0] = pend;
            ADR_IRQ_EN:  rd_data[N_PULS-1:0] = irq_en;
            ADR_EDGE:    rd_data[N_PULS-1:0] = edge_cfg;
            ADR_DEB_CFG: rd_data[DEB_W-1:0]  = deb_cfg;
            default:     rd_data = '0;
        endcase
    end

    // Ack alternates under a held strobe, giving one wait state per access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack      <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            ack <= access;
            if (access) begin
                wb_dat_o <= rd_data;
            end
        end
    end

    // A new event outranks a simultaneous W1C so no press is ever lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= '0;
            irq_en   <= '0;
            edge_cfg <= '1;
            deb_cfg  <= DEB_W'(DEB_RST);
        end else begin
            pend <= (pend & ~pend_clr) | ev;
            if (wr) begin
                case (adr)
                    ADR_IRQ_EN:  irq_en   <= wb_dat_i[N_PULS-1:0];
                    ADR_EDGE:    edge_cfg <= wb_dat_i[N_PULS-1:0];
                    ADR_DEB_CFG: deb_cfg  <= wb_dat_i[DEB_W-1:0];
                    default:     ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wb_puls_ctrl.sv
// Randomised bench for wb_puls_ctrl with a behavioural button/register model,
// a per-cycle compare process and literal checks of the directed scenarios.
module tb_wb_puls_ctrl;

    logic        clk;
    logic        reset;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [31:0] wb_wdat;
    logic [31:0] wb_rdat;
    logic        intr;
    logic [1:0]  puls_in;

    int vectors = 0;
    int miscompares = 0;

    wb_puls_ctrl #(.N_PULS(2), .DEB_W(16), .DEB_RST(1000)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_stb_i (wb_stb),
        .wb_cyc_i (wb_cyc),
        .wb_ack_o (wb_ack),
        .wb_we_i  (wb_we),
        .wb_adr_i (wb_adr),
        .wb_sel_i (wb_sel),
        .wb_dat_i (wb_wdat),
        .wb_dat_o (wb_rdat),
        .intr     (intr),
        .puls_in  (puls_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [1:0]  m_raw_q1, m_raw_q2;
    logic [1:0]  m_level, m_pend, m_irq, m_edge;
    logic [15:0] m_cfg;
    logic        m_ack;
    logic [31:0] m_dat;
    int          m_run [2];

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return {30'b0, m_level};
            8'h04:   return {30'b0, m_pend};
            8'h08:   return {30'b0, m_irq};
            8'h0C:   return {30'b0, m_edge};
            8'h10:   return {16'b0, m_cfg};
            default: return 32'h0;
        endcase
    endfunction

    // A channel's level flips once the synchronised input has disagreed with it
    // for max(cfg,1) consecutive cycles; pending bits gather matching flips.
    always @(posedge clk or posedge reset) begin : model
        logic [1:0] ev, clr, s;
        logic       accept;
        int         need;
        if (reset) begin
            m_raw_q1 = '0; m_raw_q2 = '0; m_level = '0; m_pend = '0;
            m_irq = '0; m_edge = 2'b11; m_cfg = 16'd1000; m_ack = 1'b0; m_dat = '0;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            ev = '0; clr = '0;
            s = m_raw_q2;
            need = (m_cfg < 16'd2) ? 1 : int'(m_cfg);
            accept = wb_stb && wb_cyc && !m_ack;
            if (accept) m_dat = model_read(wb_adr[7:0]);
            for (int ch = 0; ch < 2; ch++) begin
                if (s[ch] == m_level[ch]) begin
                    m_run[ch] = 0;
                end else begin
                    m_run[ch] = m_run[ch] + 1;
                    if (m_run[ch] >= need) begin
                        m_level[ch] = s[ch];
                        m_run[ch] = 0;
                        ev[ch] = (s[ch] == m_edge[ch]);
                    end
                end
            end
            if (accept && wb_we) begin
                case (wb_adr[7:0])
                    8'h04: clr = wb_wdat[1:0];
                    8'h08: m_irq = wb_wdat[1:0];
                    8'h0C: m_edge = wb_wdat[1:0];
                    8'h10: m_cfg = wb_wdat[15:0];
                    default: ;
                endcase
            end
            m_pend = (m_pend & ~clr) | ev;
            m_ack = accept;
            m_raw_q2 = m_raw_q1;
            m_raw_q1 = puls_in;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: bus handshake, interrupt and read data every cycle
    always @(negedge clk) begin
        check_output("ack", {31'b0, wb_ack}, {31'b0, wb_stb & wb_cyc & m_ack});
        check_output("intr", {31'b0, intr}, {31'b0, |(m_pend & m_irq)});
        if (wb_ack && m_ack) check_output("rdata", wb_rdat, m_dat);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                  output logic [31:0] rdata);
        logic got;
        got = 1'b0;
        rdata = '0;
        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_wdat = dat; wb_sel = 4'hF;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                got = 1'b1;
                rdata = wb_rdat;
            end
        end
        if (!got) check_output("ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    initial begin : timeout
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        logic [31:0] rd;
        int          lat;
        logic        found;
        int          exp_pat [6];
        logic [7:0]  adr_list [8];
        exp_pat  = '{0, 1, 0, 1, 0, 1};
        adr_list = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h01};

        reset = 1'b1;
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_wdat = '0; wb_sel = 4'hF;
        puls_in = 2'b00;
        repeat (3) tick();
        check_output("reset_dat", wb_rdat, 32'h0);
        reset = 1'b0;
        tick();

        apply_stimulus(1'b0, 32'h00, 32'h0, rd); check_output("def_level", rd, 32'h0);
        apply_stimulus(1'b0, 32'h04, 32'h0, rd); check_output("def_pend", rd, 32'h0);
        apply_stimulus(1'b0, 32'h08, 32'h0, rd); check_output("def_irq_en", rd, 32'h0);
        apply_stimulus(1'b0, 32'h0C, 32'h0, rd); check_output("def_edge", rd, 32'h3);
        apply_stimulus(1'b0, 32'h10, 32'h0, rd); check_output("def_deb_cfg", rd, 32'd1000);
        check_output("def_intr", {31'b0, intr}, 32'h0);

        apply_stimulus(1'b1, 32'h10, 32'd4, rd);
        apply_stimulus(1'b1, 32'h08, 32'h1, rd);
        repeat (10) tick();

        puls_in[0] = 1'b1;
        lat = 0; found = 1'b0;
        for (int n = 1; n <= 20 && !found; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (intr) begin found = 1'b1; lat = n; end
        end
        check_output("press_latency", lat, 32'd6);
        tick();
        apply_stimulus(1'b0, 32'h00, 32'h0, rd); check_output("press_level", rd, 32'h1);
        apply_stimulus(1'b0, 32'h04, 32'h0, rd); check_output("press_pend", rd, 32'h1);
        apply_stimulus(1'b1, 32'h04, 32'h1, rd);
        check_output("w1c_intr", {31'b0, intr}, 32'h0);

        puls_in[1] = 1'b1;
        repeat (3) tick();
        puls_in[1] = 1'b0;
        repeat (10) tick();
        apply_stimulus(1'b0, 32'h00, 32'h0, rd); check_output("glitch_level", rd, 32'h1);
        apply_stimulus(1'b0, 32'h04, 32'h0, rd); check_output("glitch_pend", rd, 32'h0);

        apply_stimulus(1'b1, 32'h0C, 32'h0, rd);
        puls_in[0] = 1'b0;
        repeat (10) tick();
        apply_stimulus(1'b0, 32'h04, 32'h0, rd); check_output("fall_pend", rd, 32'h1);
        apply_stimulus(1'b0, 32'h00, 32'h0, rd); check_output("fall_level", rd, 32'h0);
        puls_in[0] = 1'b1;
        repeat (10) tick();
        apply_stimulus(1'b0, 32'h04, 32'h0, rd); check_output("rise_ignored", rd, 32'h1);

        // Release lands on the same edge as the W1C write is accepted
        puls_in[0] = 1'b0;
        repeat (5) tick();
        apply_stimulus(1'b1, 32'h04, 32'h1, rd);
        apply_stimulus(1'b0, 32'h04, 32'h0, rd); check_output("set_wins", rd, 32'h1);
        apply_stimulus(1'b1, 32'h04, 32'h1, rd);
        apply_stimulus(1'b0, 32'h04, 32'h0, rd); check_output("w1c_clear", rd, 32'h0);

        apply_stimulus(1'b0, 32'h20, 32'h0, rd); check_output("unmapped", rd, 32'h0);

        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = 32'h0C;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_output("b2b_ack", {31'b0, wb_ack}, exp_pat[k]);
        end
        @(posedge clk);
        #2;
        wb_stb = 1'b0; wb_cyc = 1'b0;
        tick();

        for (int it = 0; it < 60; it++) begin
            logic [7:0] a;
            puls_in = 2'($urandom);
            repeat ($urandom_range(0, 8)) tick();
            if ($urandom_range(0, 5) == 0) begin
                apply_stimulus(1'b1, ($urandom & 32'hFFFFFF00) | 32'h10,
                               ($urandom & 32'hFFFF0000) | $urandom_range(0, 5), rd);
            end else begin
                a = adr_list[$urandom_range(0, 7)];
                apply_stimulus((a != 8'h10) ? 1'($urandom) : 1'b0,
                               ($urandom & 32'hFFFFFF00) | {24'b0, a}, $urandom, rd);
            end
        end

        wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b1; wb_adr = 32'h0C; wb_wdat = 32'h0;
        reset = 1'b1;
        repeat (2) tick();
        check_output("abort_ack", {31'b0, wb_ack}, 32'h0);
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        apply_stimulus(1'b0, 32'h0C, 32'h0, rd); check_output("post_abort_edge", rd, 32'h3);
        apply_stimulus(1'b0, 32'h10, 32'h0, rd); check_output("post_abort_cfg", rd, 32'd1000);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
